// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: state, owner and operation encodings shared by the memory arbiter
package mem_arb_pkg;
    typedef enum logic [1:0] {IDLE = 2'b00, BUSY = 2'b01, DRAIN = 2'b10} state_t;
    typedef enum logic {OWN_I = 1'b0, OWN_D = 1'b1} owner_t;
    typedef enum logic {OP_RD = 1'b0, OP_WR = 1'b1} op_t;
endpackage

// File: rtl/mem_arb_starve.sv
// mem_arb_starve: saturating count of data grants taken while instruction waits
module mem_arb_starve
    import mem_arb_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic i_req,
    input  logic i_gnt_d,
    input  logic i_gnt_i,
    output logic o_force_i
);
    logic [3:0] r_cnt;
    logic       w_sat;
    assign w_sat     = r_cnt == 4'(STARVE_LIMIT);
    assign o_force_i = i_req & w_sat;
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_cnt <= '0;
        else if (i_gnt_i)
            r_cnt <= '0;
        else if (i_gnt_d)
            r_cnt <= !i_req ? 4'd0 : w_sat ? r_cnt : r_cnt + 4'd1;
    end
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one mem_system between instruction fetch and data ports,
// data first with a starvation guard, watchdog abort and drain of hung accesses
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int STARVE_LIMIT = 4,
    parameter int TIMEOUT_CYC  = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_req,
    input  logic [15:0] i_addr,
    output logic [15:0] i_data_out,
    output logic        i_done,
    output logic        i_stall,
    output logic        i_hit,
    output logic        i_err,
    input  logic        d_rd,
    input  logic        d_wr,
    input  logic [15:0] d_addr,
    input  logic [15:0] d_data_in,
    output logic [15:0] d_data_out,
    output logic        d_done,
    output logic        d_stall,
    output logic        d_hit,
    output logic        d_err,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_data_in,
    output logic        mem_rd,
    output logic        mem_wr,
    input  logic [15:0] mem_data_out,
    input  logic        mem_done,
    input  logic        mem_stall,
    input  logic        mem_hit,
    input  logic        mem_err,
    output logic        gnt_i,
    output logic        gnt_d
);
    state_t      r_state, w_next;
    owner_t      r_owner;
    op_t         r_op;
    logic [15:0] r_addr, r_wdata;
    logic [7:0]  r_wd;
    logic        w_live, w_idle, w_busy, w_act, w_force_i, w_gnt_d, w_gnt_i;
    logic        w_d_ill, w_fin, w_to, w_done, w_i_fin, w_d_fin, w_unused;
    assign w_unused = mem_stall;
    assign w_live   = ~rst;
    assign w_idle   = r_state == IDLE;
    assign w_busy   = r_state == BUSY;
    assign w_act    = w_live & ~w_idle;
    assign w_d_ill  = w_idle & d_rd & d_wr;
    assign w_gnt_d  = w_idle & (d_rd ^ d_wr) & ~w_force_i;
    assign w_gnt_i  = w_idle & ~w_gnt_d & i_req;
    assign w_fin    = w_busy & mem_done;
    assign w_to     = w_busy & ~mem_done & (r_wd == 8'(TIMEOUT_CYC - 1));
    assign w_done   = w_fin | w_to;
    mem_arb_starve #(.STARVE_LIMIT(STARVE_LIMIT)) u_starve (
        .clk       (clk),
        .rst       (rst),
        .i_req     (i_req),
        .i_gnt_d   (w_gnt_d),
        .i_gnt_i   (w_gnt_i),
        .o_force_i (w_force_i)
    );
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end
    always_comb begin
        w_next = r_state;
        w_next = w_idle ? ((w_gnt_d | w_gnt_i) ? BUSY : IDLE)
               : w_busy ? (w_fin ? IDLE : w_to ? DRAIN : BUSY)
               : (mem_done ? IDLE : DRAIN);
    end
    // The request is captured at grant so mem_system sees a stable op for the whole access.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_owner <= OWN_D;
            r_op    <= OP_RD;
            r_addr  <= '0;
            r_wdata <= '0;
            r_wd    <= '0;
        end else if (w_gnt_d | w_gnt_i) begin
            r_owner <= w_gnt_d ? OWN_D : OWN_I;
            r_op    <= (w_gnt_d & d_wr) ? OP_WR : OP_RD;
            r_addr  <= w_gnt_d ? d_addr : i_addr;
            r_wdata <= w_gnt_d ? d_data_in : 16'h0;
            r_wd    <= '0;
        end else if (w_busy) begin
            r_wd <= r_wd + 8'd1;
        end
    end
    assign mem_rd      = w_act & (r_op == OP_RD);
    assign mem_wr      = w_act & (r_op == OP_WR);
    assign mem_addr    = w_act ? r_addr : 16'h0;
    assign mem_data_in = mem_wr ? r_wdata : 16'h0;
    assign gnt_i       = w_live & w_busy & (r_owner == OWN_I);
    assign gnt_d       = w_live & w_busy & (r_owner == OWN_D);
    // Timeout and illegal-request completions force err; a real completion reports mem_err.
    assign w_i_fin     = w_live & w_done & (r_owner == OWN_I);
    assign w_d_fin     = w_live & ((w_done & (r_owner == OWN_D)) | w_d_ill);
    assign i_done      = w_i_fin;
    assign i_data_out  = (w_i_fin & w_fin) ? mem_data_out : 16'h0;
    assign i_hit       = w_i_fin & w_fin & mem_hit;
    assign i_err       = w_i_fin & (w_to | mem_err);
    assign i_stall     = w_live & i_req & ~i_done;
    assign d_done      = w_d_fin;
    assign d_data_out  = (w_d_fin & w_fin) ? mem_data_out : 16'h0;
    assign d_hit       = w_d_fin & w_fin & mem_hit;
    assign d_err       = w_d_fin & (w_d_ill | w_to | mem_err);
    assign d_stall     = w_live & (d_rd | d_wr) & ~d_done;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: scoreboard bench for mem_arbiter against a small mem_system model
module tb_mem_arbiter;
    import mem_arb_pkg::*;
    typedef struct packed {
        logic        done;
        logic        port;
        logic [15:0] data;
        logic        err;
        logic        hit;
    } exp_t;
    localparam logic P_I = 1'b0;
    localparam logic P_D = 1'b1;
    logic        clk = 1'b0, rst = 1'b1;
    logic        i_req = 1'b0, d_rd = 1'b0, d_wr = 1'b0;
    logic [15:0] i_addr = '0, d_addr = '0, d_data_in = '0;
    logic [15:0] i_data_out, d_data_out, mem_addr, mem_data_in, mem_data_out;
    logic        i_done, i_stall, i_hit, i_err, d_done, d_stall, d_hit, d_err;
    logic        mem_rd, mem_wr, mem_done, mem_stall, mem_hit, mem_err, gnt_i, gnt_d;
    int          vecs = 0, miss = 0;
    exp_t        sb[$];
    exp_t        e;
    logic        hang = 1'b0, merr = 1'b0;
    int          lat = 0, cnt = 0;
    logic [15:0] store [256];
    bit          wvalid [256];

    mem_arbiter #(.STARVE_LIMIT(4), .TIMEOUT_CYC(8)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_data_out(i_data_out), .i_done(i_done),
        .i_stall(i_stall), .i_hit(i_hit), .i_err(i_err),
        .d_rd(d_rd), .d_wr(d_wr), .d_addr(d_addr), .d_data_in(d_data_in),
        .d_data_out(d_data_out), .d_done(d_done), .d_stall(d_stall), .d_hit(d_hit), .d_err(d_err),
        .mem_addr(mem_addr), .mem_data_in(mem_data_in), .mem_rd(mem_rd), .mem_wr(mem_wr),
        .mem_data_out(mem_data_out), .mem_done(mem_done), .mem_stall(mem_stall),
        .mem_hit(mem_hit), .mem_err(mem_err), .gnt_i(gnt_i), .gnt_d(gnt_d)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] seed(input logic [7:0] k);
        return (k == 8'h01) ? 16'hBEEF : {8'h5A, k};
    endfunction

    always @(posedge clk) begin
        cnt <= (mem_rd | mem_wr) ? cnt + 1 : 0;
        if (mem_wr && mem_done) begin
            store[mem_addr[11:4]]  <= mem_data_in;
            wvalid[mem_addr[11:4]] <= 1'b1;
        end
    end
    assign mem_done     = (mem_rd | mem_wr) & ~hang & (cnt >= lat);
    assign mem_data_out = mem_rd ? (wvalid[mem_addr[11:4]] ? store[mem_addr[11:4]]
                                                           : seed(mem_addr[11:4])) : 16'h0;
    assign mem_hit      = mem_done & (lat == 0);
    assign mem_err      = merr;
    assign mem_stall    = (mem_rd | mem_wr) & ~mem_done;

    function automatic exp_t observed();
        exp_t o;
        o = d_done ? '{d_done, P_D, d_data_out, d_err, d_hit}
                   : '{i_done, P_I, i_data_out, i_err, i_hit};
        return o;
    endfunction

    task automatic wait_done(input string name);
        int k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!(i_done || d_done) && k < 200);
        vecs++;
        if (!(i_done || d_done)) begin
            miss++;
            $display("FAIL %s: no done within 200 cycles, got 0 want 1", name);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; i_req = 1'b1; d_rd = 1'b1; d_wr = 1'b1; d_addr = 16'h0010;
        #1;
        vecs++;
        if ({mem_rd, mem_wr, gnt_i, gnt_d, i_done, d_done, i_err, d_err, i_stall, d_stall} !== 10'b0) begin
            miss++;
            $display("FAIL reset_outs: got %b want 0",
                     {mem_rd, mem_wr, gnt_i, gnt_d, i_done, d_done, i_err, d_err, i_stall, d_stall});
        end
        vecs++;
        if ({mem_addr, d_data_out, i_data_out} !== 48'h0) begin
            miss++;
            $display("FAIL reset_data: got %h want 0", {mem_addr, d_data_out, i_data_out});
        end
        i_req = 1'b0; d_rd = 1'b0; d_wr = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        vecs++;
        if (dut.r_state !== IDLE || dut.u_starve.r_cnt !== 4'd0) begin
            miss++;
            $display("FAIL reset_state: got %0d/%0d want 0/0", dut.r_state, dut.u_starve.r_cnt);
        end
    endtask

    task automatic test_single_read();
        @(negedge clk);
        d_rd = 1'b1; d_addr = 16'h0010;
        sb.push_back('{1'b1, P_D, 16'hBEEF, 1'b0, 1'b1});
        #1;
        vecs++;
        if ({gnt_d, mem_rd, d_done} !== 3'b000) begin
            miss++;
            $display("FAIL grant_cycle: got %b want 000", {gnt_d, mem_rd, d_done});
        end
        @(negedge clk);
        vecs++;
        if ({mem_rd, mem_addr, gnt_d, i_done, i_data_out} !== {1'b1, 16'h0010, 1'b1, 1'b0, 16'h0}) begin
            miss++;
            $display("FAIL rd_busy: got %h want %h", {mem_rd, mem_addr, gnt_d, i_done, i_data_out},
                     {1'b1, 16'h0010, 1'b1, 1'b0, 16'h0});
        end
        e = sb.pop_front();
        vecs++;
        if (observed() !== e) begin
            miss++;
            $display("FAIL rd_resp: got %h want %h", observed(), e);
        end
        d_rd = 1'b0;
    endtask

    task automatic test_collision();
        @(negedge clk);
        i_req = 1'b1; i_addr = 16'h0300;
        d_wr = 1'b1; d_addr = 16'h0200; d_data_in = 16'h1234;
        sb.push_back('{1'b1, P_D, 16'h0000, 1'b0, 1'b1});
        sb.push_back('{1'b1, P_I, 16'h5A30, 1'b0, 1'b1});
        @(negedge clk);
        vecs++;
        if ({gnt_d, gnt_i, mem_wr, mem_rd, mem_data_in, mem_addr} !== {4'b1010, 16'h1234, 16'h0200}) begin
            miss++;
            $display("FAIL coll_dwr: got %h want %h", {gnt_d, gnt_i, mem_wr, mem_rd, mem_data_in, mem_addr},
                     {4'b1010, 16'h1234, 16'h0200});
        end
        e = sb.pop_front();
        vecs++;
        if (observed() !== e) begin
            miss++;
            $display("FAIL coll_d_resp: got %h want %h", observed(), e);
        end
        d_wr = 1'b0;
        @(negedge clk);
        vecs++;
        if ({mem_rd, mem_wr, gnt_i, i_stall} !== 4'b0001) begin
            miss++;
            $display("FAIL coll_bubble: got %b want 0001", {mem_rd, mem_wr, gnt_i, i_stall});
        end
        @(negedge clk);
        vecs++;
        if ({gnt_i, mem_rd, mem_addr} !== {2'b11, 16'h0300}) begin
            miss++;
            $display("FAIL coll_igrant: got %h want %h", {gnt_i, mem_rd, mem_addr}, {2'b11, 16'h0300});
        end
        e = sb.pop_front();
        vecs++;
        if (observed() !== e) begin
            miss++;
            $display("FAIL coll_i_resp: got %h want %h", observed(), e);
        end
        i_req = 1'b0;
    endtask

    task automatic test_starve();
        @(negedge clk);
        i_req = 1'b1; i_addr = 16'h0300; d_rd = 1'b1; d_addr = 16'h0040;
        repeat (4) sb.push_back('{1'b1, P_D, 16'h5A04, 1'b0, 1'b1});
        sb.push_back('{1'b1, P_I, 16'h5A30, 1'b0, 1'b1});
        for (int n = 0; n < 5; n++) begin
            wait_done("starve");
            e = sb.pop_front();
            vecs++;
            if (observed() !== e) begin
                miss++;
                $display("FAIL starve_order[%0d]: got %h want %h", n, observed(), e);
            end
            if (n == 3) begin
                vecs++;
                if (dut.u_starve.r_cnt !== 4'd4) begin
                    miss++;
                    $display("FAIL starve_sat: got %0d want 4", dut.u_starve.r_cnt);
                end
            end
        end
        i_req = 1'b0; d_rd = 1'b0;
        @(negedge clk);
        vecs++;
        if (dut.u_starve.r_cnt !== 4'd0) begin
            miss++;
            $display("FAIL starve_clear: got %0d want 0", dut.u_starve.r_cnt);
        end
    endtask

    task automatic test_illegal();
        @(negedge clk);
        d_rd = 1'b1; d_wr = 1'b1; i_req = 1'b1; i_addr = 16'h0300;
        sb.push_back('{1'b1, P_D, 16'h0000, 1'b1, 1'b0});
        sb.push_back('{1'b1, P_I, 16'h5A30, 1'b0, 1'b1});
        #1;
        vecs++;
        if ({mem_rd, mem_wr, d_stall, gnt_d} !== 4'b0000) begin
            miss++;
            $display("FAIL ill_mem: got %b want 0000", {mem_rd, mem_wr, d_stall, gnt_d});
        end
        e = sb.pop_front();
        vecs++;
        if (observed() !== e) begin
            miss++;
            $display("FAIL ill_resp: got %h want %h", observed(), e);
        end
        @(negedge clk);
        vecs++;
        if ({gnt_i, gnt_d} !== 2'b10) begin
            miss++;
            $display("FAIL ill_igrant: got %b want 10", {gnt_i, gnt_d});
        end
        e = sb.pop_front();
        vecs++;
        if (observed() !== e) begin
            miss++;
            $display("FAIL ill_i_resp: got %h want %h", observed(), e);
        end
        d_rd = 1'b0; d_wr = 1'b0; i_req = 1'b0;
    endtask

    task automatic test_timeout();
        logic early = 1'b0;
        @(negedge clk);
        hang = 1'b1; d_rd = 1'b1; d_addr = 16'h0050;
        sb.push_back('{1'b1, P_D, 16'h0000, 1'b1, 1'b0});
        @(negedge clk);
        for (int k = 1; k < 8; k++) begin
            early |= d_done;
            @(negedge clk);
        end
        vecs++;
        if (early !== 1'b0) begin
            miss++;
            $display("FAIL wd_early: got done before cycle 8, want none");
        end
        e = sb.pop_front();
        vecs++;
        if (observed() !== e) begin
            miss++;
            $display("FAIL wd_resp: got %h want %h", observed(), e);
        end
        d_rd = 1'b0; i_req = 1'b1; i_addr = 16'h0300;
        repeat (3) begin
            @(negedge clk);
            vecs++;
            if ({mem_rd, mem_addr, gnt_i, gnt_d, i_done, d_done} !== {1'b1, 16'h0050, 4'b0}) begin
                miss++;
                $display("FAIL drain_hold: got %h want %h", {mem_rd, mem_addr, gnt_i, gnt_d, i_done, d_done},
                         {1'b1, 16'h0050, 4'b0});
            end
        end
        hang = 1'b0; merr = 1'b1;
        #1;
        vecs++;
        if ({mem_done, i_done, d_done, i_err, d_err} !== 5'b10000) begin
            miss++;
            $display("FAIL drain_exit: got %b want 10000", {mem_done, i_done, d_done, i_err, d_err});
        end
        @(negedge clk);
        merr = 1'b0;
        vecs++;
        if ({mem_rd, gnt_i, i_stall} !== 3'b001) begin
            miss++;
            $display("FAIL drain_idle: got %b want 001", {mem_rd, gnt_i, i_stall});
        end
        sb.push_back('{1'b1, P_I, 16'h5A30, 1'b0, 1'b1});
        wait_done("drain_next");
        e = sb.pop_front();
        vecs++;
        if (observed() !== e) begin
            miss++;
            $display("FAIL drain_next_resp: got %h want %h", observed(), e);
        end
        i_req = 1'b0;
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        lat = 2; d_rd = 1'b1; d_addr = 16'h0200;
        sb.push_back('{1'b1, P_D, 16'h1234, 1'b0, 1'b0});
        wait_done("b2b_rd");
        e = sb.pop_front();
        vecs++;
        if (observed() !== e) begin
            miss++;
            $display("FAIL b2b_rd_resp: got %h want %h", observed(), e);
        end
        d_rd = 1'b0; d_wr = 1'b1; d_addr = 16'h0210; d_data_in = 16'h7777;
        sb.push_back('{1'b1, P_D, 16'h0000, 1'b0, 1'b0});
        @(negedge clk);
        vecs++;
        if ({mem_rd, mem_wr, gnt_d} !== 3'b000) begin
            miss++;
            $display("FAIL b2b_bubble: got %b want 000", {mem_rd, mem_wr, gnt_d});
        end
        wait_done("b2b_wr");
        e = sb.pop_front();
        vecs++;
        if (observed() !== e) begin
            miss++;
            $display("FAIL b2b_wr_resp: got %h want %h", observed(), e);
        end
        lat = 0; d_wr = 1'b0; d_rd = 1'b1;
        sb.push_back('{1'b1, P_D, 16'h7777, 1'b0, 1'b1});
        wait_done("b2b_rdback");
        e = sb.pop_front();
        vecs++;
        if (observed() !== e) begin
            miss++;
            $display("FAIL b2b_rdback_resp: got %h want %h", observed(), e);
        end
        d_rd = 1'b0;
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        hang = 1'b1; d_rd = 1'b1; d_addr = 16'h0010;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        vecs++;
        if ({mem_rd, mem_wr, gnt_i, gnt_d, i_done, d_done, d_stall} !== 7'b0) begin
            miss++;
            $display("FAIL rst_mid: got %b want 0", {mem_rd, mem_wr, gnt_i, gnt_d, i_done, d_done, d_stall});
        end
        d_rd = 1'b0;
        @(negedge clk);
        rst = 1'b0; hang = 1'b0;
        i_req = 1'b1; i_addr = 16'h0300;
        sb.push_back('{1'b1, P_I, 16'h5A30, 1'b0, 1'b1});
        wait_done("rst_after");
        e = sb.pop_front();
        vecs++;
        if (observed() !== e) begin
            miss++;
            $display("FAIL rst_after_resp: got %h want %h", observed(), e);
        end
        i_req = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_collision();
        test_starve();
        test_illegal();
        test_timeout();
        test_back_to_back();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation still running at 200000, want finished");
        $fatal(1);
    end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
Two-requester arbiter that shares one mem_system instance (2-way cache plus four_bank_mem) between the instruction-fetch port and the data port of the unified-memory build. It latches the winning request, drives the mem_system Rd/Wr/Addr/DataIn handshake until Done, and routes DataOut, CacheHit and err back to the owner. Data has priority, backed by a starvation guard. A watchdog and a drain state protect against a hung cache FSM.

Parameters:
STARVE_LIMIT, 4, consecutive data grants allowed while i_req is pending before instruction is forced (1..15)
TIMEOUT_CYC, 64, cycles in BUSY without mem_done before the owner is aborted with error (2..255)

Ports:
clk  in  1  clock, all state rises on posedge
rst  in  1  asynchronous reset, active-high
i_req  in  1  instruction read request, held until i_done
i_addr  in  16  instruction address
i_data_out  out  16  read data, valid only when i_done=1
i_done  out  1  one-cycle completion pulse
i_stall  out  1  i_req & ~i_done
i_hit  out  1  mem_hit qualified by i_done
i_err  out  1  error, valid with i_done
d_rd  in  1  data read request, held until d_done
d_wr  in  1  data write request, held until d_done
d_addr  in  16  data address
d_data_in  in  16  write data
d_data_out  out  16  read data, valid when d_done=1
d_done  out  1  one-cycle completion pulse
d_stall  out  1  (d_rd|d_wr) & ~d_done
d_hit  out  1  mem_hit qualified by d_done
d_err  out  1  error, valid with d_done
mem_addr  out  16  to mem_system Addr
mem_data_in  out  16  to mem_system DataIn
mem_rd  out  1  to mem_system Rd
mem_wr  out  1  to mem_system Wr
mem_data_out  in  16  from mem_system DataOut
mem_done  in  1  from mem_system Done
mem_stall  in  1  from mem_system Stall (observed only)
mem_hit  in  1  from mem_system CacheHit
mem_err  in  1  from mem_system err
gnt_i  out  1  instruction port owns memory (BUSY)
gnt_d  out  1  data port owns memory (BUSY)

Behaviour:
- One clock; reset is asynchronous and active-high, on ports clk and rst.
- Reset, including mid-transaction: state=IDLE, owner=D, starve_cnt=0, wd_cnt=0. All outputs are 0 immediately, including mem_rd/mem_wr. Reset does not wait for mem_done.
- States: IDLE, BUSY, DRAIN.
- IDLE:
  - Grant D when (d_rd^d_wr) and not (i_req & starve_cnt==STARVE_LIMIT). Otherwise grant I when i_req.
  - Grant registers op, addr and wdata into latches, sets owner, goes to BUSY. No mem access occurs in the grant cycle.
  - d_rd&d_wr both high: illegal. Respond in the same cycle with d_done=1, d_err=1, no grant, stay IDLE. I may still be granted that cycle.
- BUSY:
  - mem_rd/mem_wr/mem_addr/mem_data_in are driven from the latches only. Requester inputs are ignored while BUSY.
  - wd_cnt increments each cycle.
  - On mem_done: owner gets done=1 combinationally in that cycle, with data_out=mem_data_out, hit=mem_hit, err=mem_err. Next state is IDLE.
  - Minimum request-to-done latency is 2 cycles (grant cycle plus a 1-cycle cache hit). Back-to-back grants have a 1-cycle IDLE bubble with mem_rd=mem_wr=0, so mem_system sees the strobe drop.
  - wd_cnt==TIMEOUT_CYC-1 without mem_done: owner gets done=1, err=1, data 0. Next state is DRAIN.
- DRAIN:
  - Keep driving the latched op until mem_done, then IDLE.
  - Output mem_data_out/hit/err are discarded, and no done is pulsed to either port.
- Starvation counter:
  - On a D grant while i_req=1: starve_cnt saturating-increments to STARVE_LIMIT.
  - On any I grant: reset to 0.
  - On a D grant with i_req=0: reset to 0.
- Outputs of the non-owner port are 0 except stall.
- mem_err on a non-done cycle is ignored; err is sampled only with mem_done.
- wd_cnt is 8 bits and clears on every grant.

Decomposition:
- Package mem_arb_pkg holds the state encoding (IDLE=2'b00, BUSY=2'b01, DRAIN=2'b10), owner encoding (OWN_I=1'b0, OWN_D=1'b1) and op encoding (OP_RD, OP_WR).
- One sub-module, mem_arb_starve: a saturating starvation counter with a force_i output.
- The FSM, latches and watchdog stay in mem_arbiter.

Test Plan:
- d_rd addr 0x0010 alone, mem_done 1 cycle after mem_rd rises -> d_done in cycle 2 with d_data_out = mem_data_out 0xBEEF; i_done stays 0.
- i_req and d_wr (addr 0x0200, data 0x1234) raised in the same cycle -> D granted first with mem_wr=1, mem_data_in=0x1234; I granted after a 1-cycle bubble.
- i_req held, d_rd re-raised after each d_done, STARVE_LIMIT=4 -> four D grants, then an I grant, then starve_cnt=0.
- Hold mem_done=0 with TIMEOUT_CYC=8 -> owner done+err on the 8th BUSY cycle; state DRAIN with mem_rd still 1; no further done until mem_done, then IDLE.
- d_rd=d_wr=1 -> same-cycle d_done=1, d_err=1, mem_rd=mem_wr=0.
- Assert rst mid-BUSY -> mem_rd/mem_wr and all done outputs 0 immediately; after release, a new request is granted normally.
